// File: rtl/head_table_lookup_pkg.sv
// Shared types for the hash table pipeline: task bundle, head fields,
// clear FSM states and the head-bypass patch helpers.
package hash_table;

    localparam int BUCKET_WIDTH   = 4;
    localparam int HEAD_PTR_WIDTH = 8;
    localparam int KEY_WIDTH      = 16;
    localparam int VALUE_WIDTH    = 16;

    typedef enum logic [1:0] {
        CMD_SEARCH = 2'd0,
        CMD_INSERT = 2'd1,
        CMD_DELETE = 2'd2,
        CMD_NOP    = 2'd3
    } ht_cmd_t;

    typedef struct packed {
        ht_cmd_t                   cmd;
        logic [KEY_WIDTH-1:0]      key;
        logic [VALUE_WIDTH-1:0]    value;
        logic [BUCKET_WIDTH-1:0]   bucket;
        logic [HEAD_PTR_WIDTH-1:0] head_ptr;
        logic                      head_ptr_val;
    } ht_pdata_t;

    typedef enum logic {
        CLR_IDLE = 1'b0,
        CLR_RUN  = 1'b1
    } clr_state_t;

    // True when a head update this cycle supersedes the task's head.
    function automatic logic ht_hit(
        input logic [BUCKET_WIDTH-1:0] bucket,
        input logic                    clr,
        input logic                    wen,
        input logic [BUCKET_WIDTH-1:0] addr
    );
        return clr || (wen && (bucket == addr));
    endfunction

    // Apply a head update to a task; a clear zeroes every head.
    function automatic ht_pdata_t ht_patch(
        input ht_pdata_t                 d,
        input logic                      clr,
        input logic                      wen,
        input logic [BUCKET_WIDTH-1:0]   addr,
        input logic [HEAD_PTR_WIDTH-1:0] ptr,
        input logic                      val
    );
        ht_pdata_t r;
        r = d;
        if (clr) begin
            r.head_ptr     = '0;
            r.head_ptr_val = 1'b0;
        end else if (wen && (d.bucket == addr)) begin
            r.head_ptr     = ptr;
            r.head_ptr_val = val;
        end
        return r;
    endfunction

endpackage

// File: rtl/head_table_if.sv
// Head update channel from the data table stage.
// master drives a bucket write; slave (lookup stage) consumes it.
interface head_table_if;
    import hash_table::*;

    logic [BUCKET_WIDTH-1:0]   wr_addr;
    logic [HEAD_PTR_WIDTH-1:0] wr_data_ptr;
    logic                      wr_data_ptr_val;
    logic                      wr_en;

    modport master (
        output wr_addr, wr_data_ptr, wr_data_ptr_val, wr_en
    );

    modport slave (
        input wr_addr, wr_data_ptr, wr_data_ptr_val, wr_en
    );
endinterface

// File: rtl/ht_pdata_patch_fifo.sv
// Output buffer whose stored tasks track head updates by bucket.
// Ports: push/pop, head_o/empty_o/used_o, patch_* head update.
module ht_pdata_patch_fifo
    import hash_table::*;
#(
    parameter int DEPTH = 4,
    parameter int UW    = $clog2(DEPTH) + 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      push_i,
    input  ht_pdata_t                 push_data_i,
    input  logic                      pop_i,
    output ht_pdata_t                 head_o,
    output logic                      empty_o,
    output logic [UW-1:0]             used_o,
    input  logic                      patch_clr_i,
    input  logic                      patch_wen_i,
    input  logic [BUCKET_WIDTH-1:0]   patch_addr_i,
    input  logic [HEAD_PTR_WIDTH-1:0] patch_ptr_i,
    input  logic                      patch_val_i
);

    localparam int AW = $clog2(DEPTH);

    ht_pdata_t     mem [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [UW-1:0] used_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            used_q   <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            used_q <= used_q + UW'(push_i) - UW'(pop_i);
        end
    end

    // Incoming entry is patched too, so a write landing on the
    // push cycle is not lost.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (push_i && (wr_ptr_q == AW'(i))) begin
                mem[i] <= ht_patch(push_data_i, patch_clr_i,
                                   patch_wen_i, patch_addr_i,
                                   patch_ptr_i, patch_val_i);
            end else begin
                mem[i] <= ht_patch(mem[i], patch_clr_i,
                                   patch_wen_i, patch_addr_i,
                                   patch_ptr_i, patch_val_i);
            end
        end
    end

    assign head_o  = mem[rd_ptr_q];
    assign empty_o = (used_q == '0);
    assign used_o  = used_q;

endmodule

// File: rtl/true_dual_port_ram_single_clock.sv
// Single-clock dual-port RAM. Port A read/write, port B write.
// Ports: clk_i; addr/data/we per port; q_a read data (1 or 2 cycle).
module true_dual_port_ram_single_clock #(
    parameter int DATA_WIDTH   = 9,
    parameter int ADDR_WIDTH   = 4,
    parameter int REGISTER_OUT = 1
) (
    input  logic                  clk_i,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [DATA_WIDTH-1:0] data_a,
    input  logic                  we_a,
    output logic [DATA_WIDTH-1:0] q_a,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0] data_b,
    input  logic                  we_b
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] q_a_raw;

    // Read-during-write on A returns old data; callers bypass.
    always_ff @(posedge clk_i) begin
        if (we_a) begin
            mem[addr_a] <= data_a;
        end
        if (we_b) begin
            mem[addr_b] <= data_b;
        end
        q_a_raw <= mem[addr_a];
    end

    generate
        if (REGISTER_OUT != 0) begin : g_reg_out
            logic [DATA_WIDTH-1:0] q_a_reg;
            always_ff @(posedge clk_i) begin
                q_a_reg <= q_a_raw;
            end
            assign q_a = q_a_reg;
        end else begin : g_raw_out
            assign q_a = q_a_raw;
        end
    endgenerate

endmodule

// File: rtl/head_table_lookup.sv
// Head table lookup stage: reads bucket head, merges it into the task.
// Ports: clk_i/rst_i, pdata_in/out handshakes, head_table_if, clear.
module head_table_lookup
    import hash_table::*;
#(
    parameter int RAM_LATENCY    = 2,
    parameter int OUT_FIFO_DEPTH = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  ht_pdata_t  pdata_in_i,
    input  logic       pdata_in_valid_i,
    output logic       pdata_in_ready_o,
    output ht_pdata_t  pdata_out_o,
    output logic       pdata_out_valid_o,
    input  logic       pdata_out_ready_i,
    head_table_if.slave head_table_if,
    input  logic       clear_ram_run_i,
    output logic       clear_ram_done_o
);

    localparam int EW = HEAD_PTR_WIDTH + 1;
    localparam int UW = $clog2(OUT_FIFO_DEPTH) + 1;
    localparam int LAST = RAM_LATENCY - 1;

    clr_state_t              clr_state_q;
    logic [BUCKET_WIDTH-1:0] clr_addr_q;
    logic                    clear_busy;
    logic                    clr_all;
    logic                    ext_wen;

    ht_pdata_t               stage_q [RAM_LATENCY];
    logic [RAM_LATENCY-1:0]  stage_vld_q;
    logic [RAM_LATENCY-1:0]  stage_ovr_q;
    logic [UW-1:0]           inflight_cnt;

    ht_pdata_t               in_clean;
    ht_pdata_t               push_data;
    logic [EW-1:0]           ram_q;
    logic                    accept;
    logic [UW-1:0]           fifo_used;
    logic                    fifo_empty;
    logic                    fifo_pop;

    assign clear_busy = (clr_state_q == CLR_RUN);
    // Zeroing starts with the request so nothing slips out with a
    // stale head between the request and the first clear write.
    assign clr_all = clear_busy ||
                     ((clr_state_q == CLR_IDLE) && clear_ram_run_i);
    assign ext_wen = head_table_if.wr_en && !clear_busy;

    assign pdata_in_ready_o = !clear_busy &&
        (({1'b0, fifo_used} + {1'b0, inflight_cnt}) <
         (UW + 1)'(OUT_FIFO_DEPTH));
    assign accept = pdata_in_valid_i && pdata_in_ready_o;

    assign clear_ram_done_o = clear_busy && (&clr_addr_q) &&
                              !clear_ram_run_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            clr_state_q <= CLR_IDLE;
            clr_addr_q  <= '0;
        end else begin
            unique case (clr_state_q)
                CLR_IDLE: begin
                    if (clear_ram_run_i) begin
                        clr_state_q <= CLR_RUN;
                        clr_addr_q  <= '0;
                    end
                end
                CLR_RUN: begin
                    if (clear_ram_run_i) begin
                        clr_addr_q <= '0;
                    end else if (&clr_addr_q) begin
                        clr_state_q <= CLR_IDLE;
                    end else begin
                        clr_addr_q <= clr_addr_q + 1'b1;
                    end
                end
                default: clr_state_q <= CLR_IDLE;
            endcase
        end
    end

    true_dual_port_ram_single_clock #(
        .DATA_WIDTH   (EW),
        .ADDR_WIDTH   (BUCKET_WIDTH),
        .REGISTER_OUT ((RAM_LATENCY >= 2) ? 1 : 0)
    ) u_head_ram (
        .clk_i  (clk_i),
        .addr_a (pdata_in_i.bucket),
        .data_a ('0),
        .we_a   (1'b0),
        .q_a    (ram_q),
        .addr_b (clear_busy ? clr_addr_q : head_table_if.wr_addr),
        .data_b (clear_busy ? EW'(0) :
                 {head_table_if.wr_data_ptr,
                  head_table_if.wr_data_ptr_val}),
        .we_b   (clear_busy || ext_wen)
    );

    always_comb begin
        in_clean              = pdata_in_i;
        in_clean.head_ptr     = '0;
        in_clean.head_ptr_val = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stage_vld_q  <= '0;
            inflight_cnt <= '0;
        end else begin
            stage_vld_q[0] <= accept;
            for (int i = 1; i < RAM_LATENCY; i++) begin
                stage_vld_q[i] <= stage_vld_q[i-1];
            end
            inflight_cnt <= inflight_cnt + UW'(accept) -
                            UW'(stage_vld_q[LAST]);
        end
    end

    // Override flag: a head update seen after the RAM read means the
    // carried head, not the RAM data, is authoritative.
    always_ff @(posedge clk_i) begin
        stage_q[0] <= ht_patch(in_clean, clr_all, ext_wen,
                               head_table_if.wr_addr,
                               head_table_if.wr_data_ptr,
                               head_table_if.wr_data_ptr_val);
        stage_ovr_q[0] <= ht_hit(in_clean.bucket, clr_all, ext_wen,
                                 head_table_if.wr_addr);
        for (int i = 1; i < RAM_LATENCY; i++) begin
            stage_q[i] <= ht_patch(stage_q[i-1], clr_all, ext_wen,
                                   head_table_if.wr_addr,
                                   head_table_if.wr_data_ptr,
                                   head_table_if.wr_data_ptr_val);
            stage_ovr_q[i] <= stage_ovr_q[i-1] |
                ht_hit(stage_q[i-1].bucket, clr_all, ext_wen,
                       head_table_if.wr_addr);
        end
    end

    always_comb begin
        push_data = stage_q[LAST];
        if (!stage_ovr_q[LAST]) begin
            push_data.head_ptr     = ram_q[EW-1:1];
            push_data.head_ptr_val = ram_q[0];
        end
    end

    assign pdata_out_valid_o = !fifo_empty;
    assign fifo_pop = !fifo_empty && pdata_out_ready_i;

    ht_pdata_patch_fifo #(
        .DEPTH (OUT_FIFO_DEPTH),
        .UW    (UW)
    ) u_out_fifo (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .push_i       (stage_vld_q[LAST]),
        .push_data_i  (push_data),
        .pop_i        (fifo_pop),
        .head_o       (pdata_out_o),
        .empty_o      (fifo_empty),
        .used_o       (fifo_used),
        .patch_clr_i  (clr_all),
        .patch_wen_i  (ext_wen),
        .patch_addr_i (head_table_if.wr_addr),
        .patch_ptr_i  (head_table_if.wr_data_ptr),
        .patch_val_i  (head_table_if.wr_data_ptr_val)
    );

endmodule
